// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating the MEM stage and instruction fetch
// Optional `MEMCTRL_IOFULL_EN adds io_buffer_full back-pressure on I/O-mapped write bytes.
module mem_ctrl #(
   parameter int          ADDR_WIDTH   = 32,
   parameter logic [31:0] IO_ADDR_BASE = 32'h00030000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic                  if_done,
   output logic [31:0]           if_data,
   input  logic                  mem_req,
   input  logic                  mem_rw,
   input  logic [1:0]            mem_len,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_wdata,
   output logic                  mem_done,
   output logic [31:0]           mem_rdata,
`ifdef MEMCTRL_IOFULL_EN
   input  logic                  io_buffer_full,
`endif
   input  logic [7:0]            ram_din,
   output logic [7:0]            ram_dout,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wr
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                state, state_n;
   logic [2:0]            cnt, cnt_n;
   logic [2:0]            n_bytes, n_bytes_n;
   logic                  owner_mem, owner_mem_n;
   logic                  rw, rw_n;
   logic [ADDR_WIDTH-1:0] base, base_n;
   logic [31:0]           wdata, wdata_n;
   logic [31:0]           rbuf, rbuf_n;
   logic                  if_done_n, mem_done_n, ram_wr_n;
   logic [31:0]           if_data_n, mem_rdata_n;
   logic [7:0]            ram_dout_n;
   logic [ADDR_WIDTH-1:0] ram_addr_n;

   logic                  io_full;
   logic [ADDR_WIDTH-1:0] io_base;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [2:0]            cnt_m2;
   logic [2:0]            req_n_bytes;

`ifdef MEMCTRL_IOFULL_EN
   assign io_full = io_buffer_full;
`else
   assign io_full = 1'b0;
`endif

   assign io_base    = ADDR_WIDTH'(IO_ADDR_BASE);
   assign issue_addr = base + ADDR_WIDTH'(cnt);
   assign cnt_m2     = cnt - 3'd2;

   always_comb begin
      req_n_bytes = 3'd4;
      case (mem_len)
         2'b00:   req_n_bytes = 3'd1;
         2'b01:   req_n_bytes = 3'd2;
         default: req_n_bytes = 3'd4;
      endcase
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      n_bytes_n   = n_bytes;
      owner_mem_n = owner_mem;
      rw_n        = rw;
      base_n      = base;
      wdata_n     = wdata;
      rbuf_n      = rbuf;
      if_done_n   = 1'b0;
      mem_done_n  = 1'b0;
      ram_wr_n    = 1'b0;
      if_data_n   = if_data;
      mem_rdata_n = mem_rdata;
      ram_dout_n  = ram_dout;
      ram_addr_n  = ram_addr;

      case (state)
         S_IDLE: begin
            if (mem_req) begin
               state_n     = S_BUSY;
               owner_mem_n = 1'b1;
               rw_n        = mem_rw;
               n_bytes_n   = req_n_bytes;
               base_n      = mem_addr;
               wdata_n     = mem_wdata;
               rbuf_n      = 32'd0;
               ram_addr_n  = mem_addr;
               cnt_n       = 3'd1;
               if (mem_rw) begin
                  // A stalled first byte is reissued from BUSY with the counter parked at 0.
                  if (io_full && (mem_addr >= io_base)) begin
                     cnt_n = 3'd0;
                  end else begin
                     ram_dout_n = mem_wdata[7:0];
                     ram_wr_n   = 1'b1;
                  end
               end
            end else if (if_req && !if_flush) begin
               state_n     = S_BUSY;
               owner_mem_n = 1'b0;
               rw_n        = 1'b0;
               n_bytes_n   = 3'd4;
               base_n      = if_addr;
               rbuf_n      = 32'd0;
               ram_addr_n  = if_addr;
               cnt_n       = 3'd1;
            end
         end

         S_BUSY: begin
            if (!owner_mem && if_flush) begin
               state_n = S_IDLE;
               cnt_n   = 3'd0;
            end else if (rw) begin
               if (cnt < n_bytes) begin
                  if (!(io_full && (issue_addr >= io_base))) begin
                     ram_addr_n = issue_addr;
                     ram_dout_n = wdata[{cnt[1:0], 3'b000} +: 8];
                     ram_wr_n   = 1'b1;
                     cnt_n      = cnt + 3'd1;
                  end
               end else begin
                  mem_done_n = 1'b1;
                  state_n    = S_DONE;
                  cnt_n      = 3'd0;
               end
            end else begin
               if (cnt < n_bytes) begin
                  ram_addr_n = issue_addr;
               end
               // Byte k arrives two edges after it was addressed.
               if (cnt >= 3'd2) begin
                  rbuf_n[{cnt_m2[1:0], 3'b000} +: 8] = ram_din;
               end
               if (cnt == n_bytes + 3'd1) begin
                  state_n = S_DONE;
                  cnt_n   = 3'd0;
                  if (owner_mem) begin
                     mem_done_n  = 1'b1;
                     mem_rdata_n = rbuf_n;
                  end else begin
                     if_done_n = 1'b1;
                     if_data_n = rbuf_n;
                  end
               end else begin
                  cnt_n = cnt + 3'd1;
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         n_bytes   <= 3'd0;
         owner_mem <= 1'b0;
         rw        <= 1'b0;
         base      <= '0;
         wdata     <= 32'd0;
         rbuf      <= 32'd0;
         if_done   <= 1'b0;
         if_data   <= 32'd0;
         mem_done  <= 1'b0;
         mem_rdata <= 32'd0;
         ram_dout  <= 8'd0;
         ram_addr  <= '0;
         ram_wr    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         n_bytes   <= n_bytes_n;
         owner_mem <= owner_mem_n;
         rw        <= rw_n;
         base      <= base_n;
         wdata     <= wdata_n;
         rbuf      <= rbuf_n;
         if_done   <= if_done_n;
         if_data   <= if_data_n;
         mem_done  <= mem_done_n;
         mem_rdata <= mem_rdata_n;
         ram_dout  <= ram_dout_n;
         ram_addr  <= ram_addr_n;
         ram_wr    <= ram_wr_n;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
`timescale 1ns/1ps
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, if_done;
   logic [31:0] if_addr, if_data;
   logic        mem_req, mem_rw, mem_done;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_addr;
   logic        ram_wr;
`ifdef MEMCTRL_IOFULL_EN
   logic        io_buffer_full;
`endif

   int assertions = 0;
   int failures   = 0;
   int if_done_seen = 0;

   logic [7:0]  ram_mem [0:65535];
   logic [31:0] obs_addr [0:31];
   logic        obs_wr   [0:31];
   logic [7:0]  obs_dout [0:31];

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_WIDTH(32), .IO_ADDR_BASE(32'h00030000)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_data(if_data),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_len(mem_len),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
`ifdef MEMCTRL_IOFULL_EN
      .io_buffer_full(io_buffer_full),
`endif
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
   );

   // RAM: data for the address presented in one cycle appears in the next.
   always @(posedge clk) begin
      ram_din <= ram_mem[ram_addr[15:0]];
      if (ram_wr) ram_mem[ram_addr[15:0]] = ram_dout;
   end

   always @(negedge clk) if (if_done) if_done_seen++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_mem(input logic rw, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, output int cycles, output logic [31:0] rdata);
      int cyc;
      mem_req = 1'b1; mem_rw = rw; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      tick;
      cyc = 0;
      obs_addr[0] = ram_addr; obs_wr[0] = ram_wr; obs_dout[0] = ram_dout;
      while (!mem_done && cyc < 20) begin
         tick;
         cyc++;
         obs_addr[cyc] = ram_addr; obs_wr[cyc] = ram_wr; obs_dout[cyc] = ram_dout;
      end
      mem_req = 1'b0;
      cycles = mem_done ? cyc : -1;
      rdata = mem_rdata;
      tick;
   endtask

   task automatic do_if(input logic [31:0] addr, output int cycles, output logic [31:0] data);
      int cyc;
      if_req = 1'b1; if_addr = addr;
      tick;
      cyc = 0;
      obs_addr[0] = ram_addr; obs_wr[0] = ram_wr;
      while (!if_done && cyc < 20) begin
         tick;
         cyc++;
         obs_addr[cyc] = ram_addr; obs_wr[cyc] = ram_wr;
      end
      if_req = 1'b0;
      cycles = if_done ? cyc : -1;
      data = if_data;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick; tick;
      assertions++;
      if ({if_done, mem_done, ram_wr} !== 3'b000) begin
         failures++;
         $display("FAIL reset_strobes: got %b want 000", {if_done, mem_done, ram_wr});
      end
      assertions++;
      if ({ram_addr, ram_dout} !== 40'd0) begin
         failures++;
         $display("FAIL reset_ram_bus: got addr %h dout %h want 0", ram_addr, ram_dout);
      end
      assertions++;
      if ({if_data, mem_rdata} !== 64'd0) begin
         failures++;
         $display("FAIL reset_data: got if_data %h mem_rdata %h want 0", if_data, mem_rdata);
      end
      rst = 1'b1;
      tick;
      mem_req = 1'b1; mem_rw = 1'b1; mem_len = 2'b10; mem_addr = 32'h2200; mem_wdata = 32'h11223344;
      tick;
      assertions++;
      if (ram_wr !== 1'b1 || ram_dout !== 8'h44) begin
         failures++;
         $display("FAIL reset_pre_write: got wr %b dout %h want 1 44", ram_wr, ram_dout);
      end
      tick;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         assertions++;
         if ({ram_wr, mem_done, if_done, ram_addr, ram_dout} !== 43'd0) begin
            failures++;
            $display("FAIL reset_mid_write[%0d]: got wr %b done %b addr %h dout %h want all 0",
                     i, ram_wr, mem_done, ram_addr, ram_dout);
         end
      end
      rst = 1'b1; mem_req = 1'b0;
      tick; tick;
      assertions++;
      if ({ram_wr, mem_done, ram_addr} !== 34'd0) begin
         failures++;
         $display("FAIL reset_release_idle: got wr %b done %b addr %h want 0 0 0", ram_wr, mem_done, ram_addr);
      end
   endtask

   task automatic test_if_read;
      int cyc;
      logic [31:0] d;
      ram_mem[16'h1000] = 8'h13; ram_mem[16'h1001] = 8'h05;
      ram_mem[16'h1002] = 8'h00; ram_mem[16'h1003] = 8'h00;
      do_if(32'h1000, cyc, d);
      assertions++;
      if (cyc !== 5) begin
         failures++;
         $display("FAIL if_latency: got %0d want 5", cyc);
      end
      assertions++;
      if (d !== 32'h00000513) begin
         failures++;
         $display("FAIL if_data: got %h want 00000513", d);
      end
      for (int k = 0; k < 4; k++) begin
         assertions++;
         if (obs_addr[k] !== 32'h1000 + k || obs_wr[k] !== 1'b0) begin
            failures++;
            $display("FAIL if_addr_seq[%0d]: got %h wr %b want %h wr 0", k, obs_addr[k], obs_wr[k], 32'h1000 + k);
         end
      end
      assertions++;
      if (obs_addr[4] !== 32'h1003) begin
         failures++;
         $display("FAIL if_addr_hold: got %h want 00001003", obs_addr[4]);
      end
      assertions++;
      if (if_done !== 1'b0) begin
         failures++;
         $display("FAIL if_done_pulse_width: got %b want 0", if_done);
      end
   endtask

   task automatic test_mem_write;
      int cyc;
      logic [31:0] d;
      logic [31:0] w;
      w = 32'hDEADBEEF;
      do_mem(1'b1, 2'b10, 32'h2000, w, cyc, d);
      assertions++;
      if (cyc !== 4) begin
         failures++;
         $display("FAIL wr_latency: got %0d want 4", cyc);
      end
      for (int k = 0; k < 4; k++) begin
         assertions++;
         if (obs_addr[k] !== 32'h2000 + k || obs_wr[k] !== 1'b1 || obs_dout[k] !== w[8*k +: 8]) begin
            failures++;
            $display("FAIL wr_byte[%0d]: got addr %h wr %b dout %h want %h 1 %h",
                     k, obs_addr[k], obs_wr[k], obs_dout[k], 32'h2000 + k, w[8*k +: 8]);
         end
      end
      assertions++;
      if (obs_wr[4] !== 1'b0) begin
         failures++;
         $display("FAIL wr_strobe_end: got %b want 0", obs_wr[4]);
      end
      do_mem(1'b1, 2'b01, 32'h2300, 32'h1234CAFE, cyc, d);
      assertions++;
      if (cyc !== 2 || obs_dout[0] !== 8'hFE || obs_dout[1] !== 8'hCA || obs_wr[1] !== 1'b1 || obs_wr[2] !== 1'b0) begin
         failures++;
         $display("FAIL wr_half: got cyc %0d bytes %h %h wr %b%b want 2 FE CA 10",
                  cyc, obs_dout[0], obs_dout[1], obs_wr[1], obs_wr[2]);
      end
   endtask

   task automatic test_mem_read;
      int cyc;
      logic [31:0] d;
      do_mem(1'b0, 2'b01, 32'h2002, 32'd0, cyc, d);
      assertions++;
      if (cyc !== 3 || d !== 32'h0000DEAD) begin
         failures++;
         $display("FAIL rd_half: got cyc %0d data %h want 3 0000DEAD", cyc, d);
      end
      ram_mem[16'h2100] = 8'h80;
      do_mem(1'b0, 2'b00, 32'h2100, 32'd0, cyc, d);
      assertions++;
      if (cyc !== 2 || d !== 32'h00000080) begin
         failures++;
         $display("FAIL rd_byte: got cyc %0d data %h want 2 00000080", cyc, d);
      end
      assertions++;
      if (if_data !== 32'h00000513) begin
         failures++;
         $display("FAIL if_data_hold: got %h want 00000513", if_data);
      end
      ram_mem[16'hFFFE] = 8'h11; ram_mem[16'hFFFF] = 8'h22;
      ram_mem[16'h0000] = 8'h33; ram_mem[16'h0001] = 8'h44;
      do_mem(1'b0, 2'b11, 32'hFFFFFFFE, 32'd0, cyc, d);
      assertions++;
      if (cyc !== 5 || d !== 32'h44332211) begin
         failures++;
         $display("FAIL rd_wrap: got cyc %0d data %h want 5 44332211", cyc, d);
      end
      assertions++;
      if (obs_addr[1] !== 32'hFFFFFFFF || obs_addr[2] !== 32'h0 || obs_addr[3] !== 32'h1) begin
         failures++;
         $display("FAIL rd_wrap_addr: got %h %h %h want FFFFFFFF 0 1", obs_addr[1], obs_addr[2], obs_addr[3]);
      end
   endtask

   task automatic test_arbitration;
      int cyc;
      ram_mem[16'h1010] = 8'h93; ram_mem[16'h1011] = 8'h00;
      ram_mem[16'h1012] = 8'h10; ram_mem[16'h1013] = 8'h00;
      if_req = 1'b1; if_addr = 32'h1010;
      mem_req = 1'b1; mem_rw = 1'b0; mem_len = 2'b00; mem_addr = 32'h2100;
      tick;
      assertions++;
      if (ram_addr !== 32'h2100) begin
         failures++;
         $display("FAIL arb_mem_first: got %h want 00002100", ram_addr);
      end
      cyc = 0;
      while (!mem_done && cyc < 20) begin tick; cyc++; end
      assertions++;
      if (cyc !== 2 || mem_rdata !== 32'h80 || if_done !== 1'b0) begin
         failures++;
         $display("FAIL arb_mem_done: got cyc %0d data %h if_done %b want 2 80 0", cyc, mem_rdata, if_done);
      end
      mem_req = 1'b0;
      tick;
      assertions++;
      if (ram_addr !== 32'h2100) begin
         failures++;
         $display("FAIL arb_no_accept_in_done: got %h want 00002100", ram_addr);
      end
      tick;
      assertions++;
      if (ram_addr !== 32'h1010) begin
         failures++;
         $display("FAIL arb_if_accept: got %h want 00001010", ram_addr);
      end
      cyc = 0;
      while (!if_done && cyc < 20) begin tick; cyc++; end
      assertions++;
      if (cyc !== 5 || if_data !== 32'h00100093) begin
         failures++;
         $display("FAIL arb_if_done: got cyc %0d data %h want 5 00100093", cyc, if_data);
      end
      if_req = 1'b0;
      tick;
   endtask

   task automatic test_flush;
      int cyc;
      int seen0;
      seen0 = if_done_seen;
      if_req = 1'b1; if_addr = 32'h1000;
      tick; tick;
      if_flush = 1'b1; if_req = 1'b0;
      mem_req = 1'b1; mem_rw = 1'b0; mem_len = 2'b00; mem_addr = 32'h2100;
      tick;
      assertions++;
      if (ram_wr !== 1'b0 || if_done !== 1'b0 || ram_addr !== 32'h1001) begin
         failures++;
         $display("FAIL flush_abort: got wr %b if_done %b addr %h want 0 0 00001001", ram_wr, if_done, ram_addr);
      end
      if_flush = 1'b0;
      tick;
      assertions++;
      if (ram_addr !== 32'h2100) begin
         failures++;
         $display("FAIL flush_mem_accept: got %h want 00002100", ram_addr);
      end
      cyc = 0;
      while (!mem_done && cyc < 20) begin tick; cyc++; end
      assertions++;
      if (cyc !== 2 || mem_rdata !== 32'h80) begin
         failures++;
         $display("FAIL flush_mem_done: got cyc %0d data %h want 2 80", cyc, mem_rdata);
      end
      mem_req = 1'b0;
      for (int i = 0; i < 6; i++) tick;
      assertions++;
      if (if_done_seen !== seen0 || if_data !== 32'h00100093) begin
         failures++;
         $display("FAIL flush_no_if_done: got pulses %0d data %h want 0 00100093", if_done_seen - seen0, if_data);
      end
   endtask

`ifdef MEMCTRL_IOFULL_EN
   task automatic test_io_full;
      int cyc;
      mem_req = 1'b1; mem_rw = 1'b1; mem_len = 2'b00; mem_addr = 32'h30000; mem_wdata = 32'h5A;
      io_buffer_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         assertions++;
         if (ram_wr !== 1'b0 || mem_done !== 1'b0) begin
            failures++;
            $display("FAIL io_stall[%0d]: got wr %b done %b want 0 0", i, ram_wr, mem_done);
         end
      end
      io_buffer_full = 1'b0;
      tick;
      assertions++;
      if (ram_wr !== 1'b1 || ram_dout !== 8'h5A || ram_addr !== 32'h30000) begin
         failures++;
         $display("FAIL io_issue: got wr %b dout %h addr %h want 1 5A 00030000", ram_wr, ram_dout, ram_addr);
      end
      cyc = 0;
      while (!mem_done && cyc < 20) begin tick; cyc++; end
      assertions++;
      if (cyc !== 1) begin
         failures++;
         $display("FAIL io_done: got %0d want 1", cyc);
      end
      mem_req = 1'b0;
      tick;
   endtask
`endif

   initial begin
      for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
      rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
      mem_req = 1'b0; mem_rw = 1'b0; mem_len = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
`ifdef MEMCTRL_IOFULL_EN
      io_buffer_full = 1'b0;
`endif
      test_reset;
      test_if_read;
      test_mem_write;
      test_mem_read;
      test_arbitration;
      test_flush;
`ifdef MEMCTRL_IOFULL_EN
      test_io_full;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-serial RAM controller and arbiter that shares the single 8-bit RAM port between instruction fetch and the MEM stage. Accepts word, halfword or byte requests, sequences them one byte per cycle on the RAM bus, assembles read data little-endian, and returns a one-cycle done pulse. The MEM stage has fixed priority over fetch. The controller sits between the pipeline (if / mem stages) and the top-level RAM pins.

Parameters:
ADDR_WIDTH, 32, width of all address ports
IO_ADDR_BASE, 32'h00030000, lowest I/O-mapped address; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (asserted when 0)
if_req  in  1  fetch request; held high until if_done
if_addr  in  ADDR_WIDTH  fetch byte address; always a 4-byte read
if_flush  in  1  cancel any pending or in-flight fetch
if_done  out  1  one-cycle pulse; if_data valid
if_data  out  32  fetched instruction word
mem_req  in  1  MEM-stage request; held high until mem_done
mem_rw  in  1  0 = read, 1 = write
mem_len  in  2  00 = byte, 01 = half, 10/11 = word
mem_addr  in  ADDR_WIDTH  MEM byte address
mem_wdata  in  32  store data; low bytes used first
mem_done  out  1  one-cycle pulse; mem_rdata valid for reads
mem_rdata  out  32  read data, zero-extended; the requester sign-extends
ram_din  in  8  RAM read byte; valid one cycle after its address is presented
ram_dout  out  8  RAM write byte
ram_addr  out  ADDR_WIDTH  RAM byte address
ram_wr  out  1  1 = write strobe this cycle

Behaviour:
- All outputs are registered.
- Reset (rst = 0 at a clk edge): all outputs are 0, state = IDLE, byte counter = 0, owner cleared. Reset mid-transfer aborts the transfer immediately. No done pulse is issued, and ram_wr is 0 the following cycle.
- States: IDLE, BUSY, DONE.
- IDLE acceptance:
  - If mem_req = 1, latch mem_addr, mem_rw, N (1/2/4 from mem_len) and mem_wdata; owner = MEM.
  - Else if if_req = 1 and if_flush = 0, latch if_addr with N = 4, read; owner = IF.
  - The accepting edge E0 already drives ram_addr = base and, for writes, ram_dout = wdata[7:0] and ram_wr = 1.
- BUSY issue: at edge E_k (k = 1..N-1), drive ram_addr = base + k. Writes drive ram_dout = wdata[8k+7:8k] with ram_wr = 1.
- Read capture: byte k (addressed at E_k) is sampled from ram_din at E_{k+2} into rdata[8k+7:8k]. Unused upper bytes are 0.
- Write completion: at E_N, ram_wr = 0 and done is set. Done is visible N cycles after acceptance.
- Read completion: at E_{N+1}, the last byte is captured and done is set. Done is visible N+1 cycles after acceptance. ram_addr holds its last value during idle cycles; ram_wr = 0.
- DONE: the owner's done pulse lasts exactly 1 cycle, then the state returns to IDLE. No request is accepted in the DONE cycle. The requester must drop req by the edge ending DONE, so the next acceptance is at the earliest one cycle after done.
- Data hold: if_data and mem_rdata hold their value until the next completion of the same owner.
- Address arithmetic: base + k is modulo 2^ADDR_WIDTH (wraps at the top address).
- Simultaneous if_req and mem_req in IDLE: MEM wins. IF waits and is not starved, because the pipeline stalls on MEM.
- No preemption: a MEM request arriving during an IF transfer waits for IF done (unless the IF transfer is flushed).
- if_flush:
  - During an IF-owned BUSY, the transfer aborts at that edge: state = IDLE, no if_done, ram_wr stays 0.
  - During MEM ownership, if_flush is ignored.
  - A flushed IF transfer may be followed in the next cycle by any request.
- if_flush and mem_req together in IDLE: MEM is accepted.

Optional Feature:
MEMCTRL_IOFULL_EN
- When defined: adds port io_buffer_full (in, 1).
- A write byte whose address is at or above IO_ADDR_BASE is not issued while io_buffer_full = 1. ram_wr is 0 and the counter holds until it clears.
- The MEM write completes correspondingly later, but done timing relative to the last issued byte is unchanged.
- When undefined: no port; writes are never stalled.

Test Plan:
1. Reset, then rst = 0 held 3 cycles mid-word-write -> ram_wr = 0, no mem_done, all outputs 0, IDLE after release.
2. IF read 0x1000, RAM bytes 13, 05, 00, 00 -> ram_addr 0x1000..0x1003 on consecutive cycles; if_done 5 cycles after accept; if_data = 0x00000513.
3. MEM write, word 0xDEADBEEF to 0x2000 -> ram_wr = 1 with EF, BE, AD, DE at 0x2000..0x2003; mem_done 4 cycles after accept.
4. MEM halfword read 0x2002 with bytes AD, DE -> mem_rdata = 0x0000DEAD, mem_done 3 cycles after accept. Byte read of 0x80 -> mem_rdata = 0x00000080.
5. if_req and mem_req asserted the same cycle -> MEM served first. IF is accepted one cycle after mem_done and completes normally.
6. if_flush two cycles into an IF fetch, with mem_req raised in the same cycle -> no if_done; MEM accepted next cycle. With MEMCTRL_IOFULL_EN, byte write to 0x30000 with io_buffer_full = 1 for 4 cycles -> ram_wr is delayed 4 cycles.
